// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing defaults and counter types for the pixel pipeline.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic in_range(input cnt_t val, input cnt_t lo, input cnt_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/pix_en_gen.sv
// Pixel clock-enable: one-mclk strobe every DIV cycles, restarting when enable drops.
module pix_en_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic enable,
    output logic pix_en
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DivMax = DW'(DIV - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (!enable || (div_q == DivMax)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_en = (div_q == DivMax);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing in the mclk domain: fetch coordinates out, registered rgb/syncs back,
// all advanced by a pixel clock-enable.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV      = 2,
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned RGB_W    = 8
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [RGB_W-1:0] pix_data,
    output logic [CNT_W-1:0] fetch_x,
    output logic [CNT_W-1:0] fetch_y,
    output logic             fetch_valid,
    output logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t HLast   = cnt_t'(HTotal - 1);
    localparam cnt_t VLast   = cnt_t'(VTotal - 1);
    localparam cnt_t HAct    = cnt_t'(H_ACTIVE);
    localparam cnt_t VAct    = cnt_t'(V_ACTIVE);
    localparam cnt_t HSyncLo = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HSyncHi = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VSyncLo = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VSyncHi = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    cnt_t             h_q, h_d, v_q, v_d;
    logic             run_q;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;

    pix_en_gen #(
        .DIV (DIV)
    ) u_pix_en_gen (
        .mclk   (mclk),
        .rst_n  (rst_n),
        .enable (enable),
        .pix_en (pix_en)
    );

    // run_q keeps fetch_valid low in the reset/disabled state, where the counters sit at (0,0).
    assign fetch_valid = run_q && (h_q < HAct) && (v_q < VAct);
    assign fetch_x     = h_q;
    assign fetch_y     = v_q;
    assign line_start  = pix_en && (h_q == HLast);
    assign frame_start = line_start && (v_q == VLast);

    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (!enable) begin
            h_d     = '0;
            v_d     = '0;
            rgb_d   = '0;
            hsync_d = ~SYNC_POL;
            vsync_d = ~SYNC_POL;
        end else if (pix_en) begin
            // Output stage samples the current fetch, so it trails fetch_* by one pixel.
            rgb_d   = fetch_valid ? pix_data : '0;
            hsync_d = in_range(h_q, HSyncLo, HSyncHi) ? SYNC_POL : ~SYNC_POL;
            vsync_d = in_range(v_q, VSyncLo, VSyncHi) ? SYNC_POL : ~SYNC_POL;
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? '0 : v_q + cnt_t'(1);
            end else begin
                h_d = h_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            run_q   <= 1'b0;
            rgb_q   <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            run_q   <= enable;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign rgb   = rgb_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: pixel-index reference model with an output scoreboard,
// a table of raster probe points, and hand sequences for reset/enable corners.
module tb_vga_timing_gen;

    localparam int unsigned DIV     = 2;
    localparam int unsigned H_TOTAL = 800;
    localparam int unsigned H_ACT   = 640;
    localparam int unsigned HS_LO   = 656;
    localparam int unsigned HS_HI   = 751;
    // Vertical timing shrunk so whole frames fit in a short run; horizontal stays at default.
    localparam int unsigned V_ACT   = 4;
    localparam int unsigned V_FP    = 2;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 2;
    localparam int unsigned V_TOTAL = 10;
    localparam int unsigned VS_LO   = 6;
    localparam int unsigned VS_HI   = 7;
    localparam int unsigned LIMIT   = 20000;

    logic       mclk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] pix_data;
    logic [9:0] fetch_x, fetch_y;
    logic       fetch_valid, pix_en, hsync, vsync, line_start, frame_start;
    logic [7:0] rgb;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } out_t;

    typedef struct {
        int unsigned h;
        int unsigned v;
        logic [7:0]  rgb;
        logic        hs;
        logic        vs;
        logic        valid;
        logic        ls;
        logic        fs;
    } probe_t;

    out_t        exp_q[$];
    out_t        cur_exp = 10'b00000000_1_1;
    int unsigned m_div = 0;
    int unsigned m_pix = 0;
    bit          m_run = 1'b0;

    always #5 mclk = ~mclk;

    vga_timing_gen #(
        .DIV      (DIV),
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pix_data    (pix_data),
        .fetch_x     (fetch_x),
        .fetch_y     (fetch_y),
        .fetch_valid (fetch_valid),
        .pix_en      (pix_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_pen();
        return m_run && (m_div == DIV - 1);
    endfunction

    // Reference model: counts pixels since the last restart; position is derived arithmetically.
    initial begin
        forever begin
            @(posedge mclk or negedge rst_n);
            if (!rst_n || !enable) begin
                m_div = 0;
                m_pix = 0;
                m_run = 1'b0;
                exp_q.delete();
                cur_exp = 10'b00000000_1_1;
            end else begin
                m_run = 1'b1;
                if (m_div == DIV - 1) begin
                    m_div = 0;
                    m_pix++;
                end else begin
                    m_div++;
                end
            end
        end
    end

    // Every-cycle compare plus pixel-output scoreboard.
    initial begin
        int unsigned h, v;
        bit          pen, val, ls, fs;
        out_t        e;
        forever begin
            @(negedge mclk);
            h   = m_pix % H_TOTAL;
            v   = (m_pix / H_TOTAL) % V_TOTAL;
            pen = model_pen();
            val = m_run && (h < H_ACT) && (v < V_ACT);
            ls  = pen && (h == H_TOTAL - 1);
            fs  = ls && (v == V_TOTAL - 1);
            pix_data = (h >= H_ACT) ? 8'hFF : 8'(h);
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            check("cycle_state", {pix_en, fetch_x, fetch_y, fetch_valid, line_start, frame_start},
                  {pen, 10'(h), 10'(v), val, ls, fs});
            check("pixel_out", {rgb, hsync, vsync}, cur_exp);
            if (pen) begin
                e.rgb = val ? pix_data : 8'h00;
                e.hs  = !((h >= HS_LO) && (h <= HS_HI));
                e.vs  = !((v >= VS_LO) && (v <= VS_HI));
                exp_q.push_back(e);
            end
        end
    end

    task automatic run_to(input int unsigned h, input int unsigned v);
        int unsigned n = 0;
        bit          hit = 1'b0;
        while (!hit && n < LIMIT) begin
            @(negedge mclk);
            n++;
            hit = model_pen() && (m_pix % H_TOTAL == h) && ((m_pix / H_TOTAL) % V_TOTAL == v);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL run_to(%0d,%0d): not reached within %0d cycles", h, v, LIMIT);
        end
    endtask

    probe_t probes[16];

    initial begin
        int unsigned npix, n;
        bit          seen;

        //          h    v   rgb    hs    vs    valid ls    fs
        probes[0]  = '{2,   0, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        probes[1]  = '{200, 0, 8'hC8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        probes[2]  = '{639, 0, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        probes[3]  = '{640, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        probes[4]  = '{655, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        probes[5]  = '{656, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        probes[6]  = '{751, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        probes[7]  = '{752, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        probes[8]  = '{799, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        probes[9]  = '{100, 3, 8'h64, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        probes[10] = '{10,  4, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        probes[11] = '{0,   6, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        probes[12] = '{799, 7, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        probes[13] = '{0,   8, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        probes[14] = '{799, 9, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        probes[15] = '{0,   0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge mclk);
        check("reset_state",
              {fetch_x, fetch_y, fetch_valid, pix_en, rgb, hsync, vsync, line_start, frame_start},
              {10'd0, 10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});

        // Release: first strobe in the second mclk, then every other one.
        enable = 1'b1;
        rst_n  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge mclk);
            check($sformatf("first_pix_en%0d", i), pix_en, (i % 2 == 0));
        end

        for (int i = 0; i < 16; i++) begin
            run_to(probes[i].h, probes[i].v);
            check($sformatf("probe%0d_strobes", i), {fetch_valid, line_start, frame_start},
                  {probes[i].valid, probes[i].ls, probes[i].fs});
            @(negedge mclk);
            check($sformatf("probe%0d_out", i), {rgb, hsync, vsync},
                  {probes[i].rgb, probes[i].hs, probes[i].vs});
        end

        // Enable drop mid-line, then a full line before the first line_start.
        run_to(300, 1);
        enable = 1'b0;
        @(negedge mclk);
        check("enable_drop",
              {fetch_x, fetch_y, fetch_valid, pix_en, rgb, hsync, vsync, line_start, frame_start},
              {10'd0, 10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
        repeat (4) @(negedge mclk);
        enable = 1'b1;
        npix = 0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 4000) begin
            @(negedge mclk);
            n++;
            if (pix_en === 1'b1) npix++;
            if (line_start === 1'b1) seen = 1'b1;
        end
        check("restart_line_pixels", npix, 800);

        // Asynchronous reset in the middle of hsync.
        run_to(700, 1);
        check("hsync_mid", hsync, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset",
              {fetch_x, fetch_y, fetch_valid, pix_en, rgb, hsync, vsync, line_start, frame_start},
              {10'd0, 10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
        @(negedge mclk);
        rst_n = 1'b1;
        repeat (3000) @(negedge mclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
